// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the memory access unit: access-size codes,
// FSM state encoding and lane-geometry helpers.
package mem_access_unit_pkg;

    localparam logic [1:0] MEM_LEN_FULL = 2'd0;
    localparam logic [1:0] MEM_LEN_BYTE = 2'd1;
    localparam logic [1:0] MEM_LEN_HALF = 2'd2;
    localparam logic [1:0] MEM_LEN_WORD = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } mau_state_e;

    // LANES = DATA_WIDTH/8; OFF_WIDTH = log2(LANES).
    function automatic int unsigned mau_lanes(int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned mau_off_width(int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering: byte enables, store shift, load
// extract/extend and misalignment detection from size and lane offset.
module mem_lane_steer
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned LANES     = mau_lanes(DATA_WIDTH),
    localparam int unsigned OFF_W     = mau_off_width(DATA_WIDTH)
) (
    input  logic [1:0]            len_i,
    input  logic [OFF_W-1:0]      off_i,
    input  logic                  unsigned_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [LANES-1:0]      be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o
);

    logic [LANES-1:0]      be_base;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic                  sign;

    assign shifted = rdata_i >> {off_i, 3'b000};
    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign be_o    = be_base << off_i;

    always_comb begin
        be_base      = '0;
        mask         = '0;
        sign         = 1'b0;
        misaligned_o = 1'b0;
        case (len_i)
            MEM_LEN_BYTE: begin
                be_base[0] = 1'b1;
                mask       = DATA_WIDTH'(8'hFF);
                sign       = shifted[7];
            end
            MEM_LEN_HALF: begin
                be_base[1:0] = 2'b11;
                mask         = DATA_WIDTH'(16'hFFFF);
                sign         = shifted[15];
                misaligned_o = off_i[0];
            end
            MEM_LEN_WORD: begin
                // On a 32-bit bus this mask is all ones, making it identical to full width.
                be_base[3:0] = 4'hF;
                mask         = DATA_WIDTH'(32'hFFFF_FFFF);
                sign         = shifted[31];
                misaligned_o = (off_i[1:0] != 2'b00);
            end
            default: begin
                be_base      = '1;
                mask         = '1;
                misaligned_o = (off_i != '0);
            end
        endcase
        rdata_o = (shifted & mask) | ((sign && !unsigned_i) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: arbitrates fetch and load/store onto one req/gnt,
// rvalid memory port with lane steering, misalignment and timeout handling.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned LANES         = mau_lanes(DATA_WIDTH),
    localparam int unsigned OFF_W         = mau_off_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_done_o,
    output logic [DATA_WIDTH-1:0] if_data_o,
    input  logic                  ls_req_i,
    input  logic                  ls_store_i,
    input  logic                  ls_unsigned_i,
    input  logic [1:0]            ls_length_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_done_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  ls_error_o,
    output logic                  if_error_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [LANES-1:0]      mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    mau_state_e            state_q, state_d;
    logic                  fetch_q, fetch_d;
    logic                  store_q, store_d;
    logic                  unsigned_q, unsigned_d;
    logic                  err_q, err_d;
    logic                  pend_q, pend_d;
    logic [1:0]            len_q, len_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LANES-1:0]      mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Transaction to launch this cycle (new request in IDLE, or pending fetch in RESP).
    logic                  nx_valid, nx_fetch, nx_store, nx_unsigned;
    logic [1:0]            nx_len;
    logic [ADDR_WIDTH-1:0] nx_addr;
    logic [DATA_WIDTH-1:0] nx_wdata;

    logic                  in_wait;
    logic [1:0]            st_len;
    logic [OFF_W-1:0]      st_off;
    logic                  st_uns;
    logic [LANES-1:0]      st_be;
    logic [DATA_WIDTH-1:0] st_wdata, st_rdata;
    logic                  st_mis;
    logic                  tmo;

    always_comb begin
        nx_valid    = 1'b0;
        nx_fetch    = 1'b0;
        nx_store    = 1'b0;
        nx_unsigned = 1'b0;
        nx_len      = MEM_LEN_FULL;
        nx_addr     = '0;
        nx_wdata    = '0;
        if (state_q == StIdle) begin
            if (ls_req_i) begin
                nx_valid    = 1'b1;
                nx_store    = ls_store_i;
                nx_unsigned = ls_unsigned_i;
                nx_len      = ls_length_i;
                nx_addr     = ls_addr_i;
                nx_wdata    = ls_wdata_i;
            end else if (if_req_i) begin
                nx_valid = 1'b1;
                nx_fetch = 1'b1;
                nx_addr  = if_addr_i;
            end
        end else if (state_q == StResp && pend_q) begin
            nx_valid = 1'b1;
            nx_fetch = 1'b1;
            nx_addr  = pend_addr_q;
        end
    end

    // One steering instance: launch-side attributes except while waiting for read data.
    assign in_wait = (state_q == StWait);
    assign st_len  = in_wait ? len_q : nx_len;
    assign st_off  = in_wait ? off_q : nx_addr[OFF_W-1:0];
    assign st_uns  = in_wait ? unsigned_q : nx_unsigned;

    mem_lane_steer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_steer (
        .len_i       (st_len),
        .off_i       (st_off),
        .unsigned_i  (st_uns),
        .wdata_i     (nx_wdata),
        .rdata_i     (mem_rdata_i),
        .be_o        (st_be),
        .wdata_o     (st_wdata),
        .rdata_o     (st_rdata),
        .misaligned_o(st_mis)
    );

    assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        store_d     = store_q;
        unsigned_d  = unsigned_q;
        err_d       = err_q;
        pend_d      = pend_q;
        len_d       = len_q;
        off_d       = off_q;
        pend_addr_d = pend_addr_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;
        cnt_d       = '0;

        case (state_q)
            StReq: begin
                if (mem_gnt_i) begin
                    state_d = store_q ? StResp : StWait;
                end else if (tmo) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    state_d = StResp;
                    if (fetch_q) begin
                        if_data_d = mem_rdata_i;
                    end else begin
                        ls_rdata_d = st_rdata;
                    end
                end else if (tmo) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                pend_d  = 1'b0;
            end
            default: begin
                if (ls_req_i && if_req_i) begin
                    pend_d      = 1'b1;
                    pend_addr_d = if_addr_i;
                end
            end
        endcase

        if (nx_valid) begin
            fetch_d    = nx_fetch;
            store_d    = nx_store;
            unsigned_d = nx_unsigned;
            len_d      = nx_len;
            off_d      = nx_addr[OFF_W-1:0];
            err_d      = st_mis;
            state_d    = st_mis ? StResp : StReq;
            if (!st_mis) begin
                mem_addr_d  = nx_addr & ~ADDR_WIDTH'(LANES - 1);
                mem_we_d    = nx_store;
                mem_be_d    = nx_store ? st_be : '1;
                mem_wdata_d = nx_store ? st_wdata : '0;
            end
        end

        // Counter restarts on every state entry and only runs in REQ/WAIT.
        if ((state_q == StReq || state_q == StWait) && state_d == state_q &&
            TIMEOUT_CYCLES != 0) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            fetch_q     <= 1'b0;
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            len_q       <= MEM_LEN_FULL;
            off_q       <= '0;
            pend_addr_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            ls_rdata_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            store_q     <= store_d;
            unsigned_q  <= unsigned_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            len_q       <= len_d;
            off_q       <= off_d;
            pend_addr_q <= pend_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req_o   = (state_q == StReq);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != StIdle);
    assign ls_done_o   = (state_q == StResp) && !fetch_q;
    assign if_done_o   = (state_q == StResp) && fetch_q;
    assign ls_error_o  = ls_done_o && err_q;
    assign if_error_o  = if_done_o && err_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign if_data_o   = if_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (32-bit bus, timeout of 8).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_store, ls_unsigned;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_length;
    logic        if_done, ls_done, ls_error, if_error, busy;
    logic [31:0] if_data, ls_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_done_o    (if_done),
        .if_data_o    (if_data),
        .ls_req_i     (ls_req),
        .ls_store_i   (ls_store),
        .ls_unsigned_i(ls_unsigned),
        .ls_length_i  (ls_length),
        .ls_addr_i    (ls_addr),
        .ls_wdata_i   (ls_wdata),
        .ls_done_o    (ls_done),
        .ls_rdata_o   (ls_rdata),
        .ls_error_o   (ls_error),
        .if_error_o   (if_error),
        .busy_o       (busy),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    // Requests must never be pulsed while the unit is busy.
    always @(posedge clk) begin
        if (rst_n) assert (!(busy && (if_req || ls_req)));
    end

    task automatic clear_inputs();
        if_req = 0; ls_req = 0; ls_store = 0; ls_unsigned = 0; ls_length = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic pulse_ls(input logic st, input logic uns, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        ls_req = 1; ls_store = st; ls_unsigned = uns; ls_length = len;
        ls_addr = addr; ls_wdata = wd;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_req, busy, ls_done, if_done, mem_we} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, busy, ls_done, if_done, mem_we});
        end
        n_cmp++;
        if ({mem_addr, if_data, ls_rdata, mem_be} !== 100'b0) begin
            n_err++; $display("FAIL reset_data: got addr=%h ifd=%h lsd=%h be=%b want 0", mem_addr, if_data, ls_rdata, mem_be);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        pulse_ls(0, 0, 2'd1, 32'h103, 0);
        @(negedge clk); ls_req = 0;
        n_cmp++;
        if ({mem_req, mem_we, busy} !== 3'b101 || mem_addr !== 32'h100 || mem_be !== 4'hF) begin
            n_err++; $display("FAIL lb_req: got req=%b we=%b busy=%b addr=%h be=%b want 1 0 1 100 1111", mem_req, mem_we, busy, mem_addr, mem_be);
        end
        mem_gnt = 1;
        @(negedge clk); mem_gnt = 0;
        n_cmp++;
        if (mem_req !== 0 || ls_done !== 0) begin
            n_err++; $display("FAIL lb_wait: got req=%b done=%b want 0 0", mem_req, ls_done);
        end
        mem_rvalid = 1; mem_rdata = 32'h8012_3456;
        @(negedge clk); mem_rvalid = 0;
        n_cmp++;
        if (ls_done !== 1 || ls_error !== 0 || ls_rdata !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL lb_done: got done=%b err=%b data=%h want 1 0 ffffff80", ls_done, ls_error, ls_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (ls_done !== 0 || busy !== 0) begin
            n_err++; $display("FAIL lb_idle: got done=%b busy=%b want 0 0", ls_done, busy);
        end
    endtask

    task automatic test_store_half();
        pulse_ls(1, 0, 2'd2, 32'h102, 32'h0000_ABCD);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); ls_req = 0; ls_store = 0;
            n_cmp++;
            if ({mem_req, mem_we} !== 2'b11 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCD_0000 ||
                mem_addr !== 32'h100) begin
                n_err++; $display("FAIL sh_req%0d: got req=%b we=%b be=%b wd=%h addr=%h want 1 1 1100 abcd0000 100", i, mem_req, mem_we, mem_be, mem_wdata, mem_addr);
            end
            if (i == 4) mem_gnt = 1;
        end
        @(negedge clk); mem_gnt = 0;
        n_cmp++;
        if (ls_done !== 1 || ls_error !== 0 || mem_req !== 0 || ls_rdata !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL sh_done: got done=%b err=%b req=%b data=%h want 1 0 0 ffffff80", ls_done, ls_error, mem_req, ls_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (ls_done !== 0 || busy !== 0) begin
            n_err++; $display("FAIL sh_idle: got done=%b busy=%b want 0 0", ls_done, busy);
        end
    endtask

    task automatic test_misaligned();
        pulse_ls(0, 0, 2'd3, 32'h101, 0);
        @(negedge clk); ls_req = 0;
        n_cmp++;
        if ({mem_req, ls_done, ls_error, busy} !== 4'b0111) begin
            n_err++; $display("FAIL mis_done: got req/done/err/busy=%b want 0111", {mem_req, ls_done, ls_error, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_req, ls_done, busy} !== 3'b000) begin
            n_err++; $display("FAIL mis_idle: got req/done/busy=%b want 000", {mem_req, ls_done, busy});
        end
    endtask

    task automatic test_fetch_priority();
        @(negedge clk);
        ls_req = 1; ls_store = 0; ls_length = 2'd3; ls_addr = 32'h200;
        if_req = 1; if_addr = 32'h40;
        @(negedge clk); ls_req = 0; if_req = 0;
        n_cmp++;
        if (mem_req !== 1 || mem_addr !== 32'h200 || busy !== 1) begin
            n_err++; $display("FAIL pri_first: got req=%b addr=%h busy=%b want 1 200 1", mem_req, mem_addr, busy);
        end
        mem_gnt = 1;
        @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1122_3344;
        @(negedge clk); mem_rvalid = 0;
        n_cmp++;
        if ({ls_done, if_done, mem_req, busy} !== 4'b1001 || ls_rdata !== 32'h1122_3344) begin
            n_err++; $display("FAIL pri_ls_done: got ls/if/req/busy=%b data=%h want 1001 11223344", {ls_done, if_done, mem_req, busy}, ls_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_req, mem_we, ls_done, busy} !== 4'b1001 || mem_addr !== 32'h40 || mem_be !== 4'hF) begin
            n_err++; $display("FAIL pri_second: got req/we/done/busy=%b addr=%h be=%b want 1001 40 1111", {mem_req, mem_we, ls_done, busy}, mem_addr, mem_be);
        end
        mem_gnt = 1;
        @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_BABE;
        n_cmp++;
        if (mem_req !== 0 || busy !== 1) begin
            n_err++; $display("FAIL pri_wait: got req=%b busy=%b want 0 1", mem_req, busy);
        end
        @(negedge clk); mem_rvalid = 0;
        n_cmp++;
        if ({if_done, if_error, ls_done} !== 3'b100 || if_data !== 32'hCAFE_BABE) begin
            n_err++; $display("FAIL pri_if_done: got if/iferr/ls=%b data=%h want 100 cafebabe", {if_done, if_error, ls_done}, if_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_done, busy} !== 2'b00) begin
            n_err++; $display("FAIL pri_idle: got if_done/busy=%b want 00", {if_done, busy});
        end
    endtask

    task automatic test_timeout();
        pulse_ls(0, 0, 2'd3, 32'h300, 0);
        @(negedge clk); ls_req = 0;
        n_cmp++;
        if (mem_req !== 1) begin
            n_err++; $display("FAIL to_req: got req=%b want 1", mem_req);
        end
        mem_gnt = 1;
        @(negedge clk); mem_gnt = 0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem_req !== 0 || ls_done !== 0 || busy !== 1) begin
                n_err++; $display("FAIL to_wait%0d: got req=%b done=%b busy=%b want 0 0 1", i, mem_req, ls_done, busy);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ls_done !== 1 || ls_error !== 1 || ls_rdata !== 32'h1122_3344) begin
            n_err++; $display("FAIL to_done: got done=%b err=%b data=%h want 1 1 11223344", ls_done, ls_error, ls_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (ls_done !== 0 || busy !== 0) begin
            n_err++; $display("FAIL to_idle: got done=%b busy=%b want 0 0", ls_done, busy);
        end
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); mem_rvalid = 0;
        n_cmp++;
        if ({ls_done, if_done, busy} !== 3'b000 || ls_rdata !== 32'h1122_3344) begin
            n_err++; $display("FAIL to_late: got done/ifdone/busy=%b data=%h want 000 11223344", {ls_done, if_done, busy}, ls_rdata);
        end
    endtask

    task automatic test_reset_mid();
        pulse_ls(0, 0, 2'd3, 32'h104, 0);
        @(negedge clk); ls_req = 0; mem_gnt = 1;
        @(negedge clk); mem_gnt = 0;
        rst_n = 0;
        #1;
        n_cmp++;
        if ({mem_req, busy, ls_done, ls_error, mem_we} !== 5'b0 || ls_rdata !== 0 ||
            if_data !== 0 || mem_addr !== 0 || mem_be !== 0) begin
            n_err++; $display("FAIL rst_mid: got ctrl=%b lsd=%h ifd=%h addr=%h be=%b want 0", {mem_req, busy, ls_done, ls_error, mem_we}, ls_rdata, if_data, mem_addr, mem_be);
        end
        @(negedge clk); rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_rvalid = 0;
            n_cmp++;
            if ({ls_done, busy} !== 2'b00 || ls_rdata !== 0) begin
                n_err++; $display("FAIL rst_nodone%0d: got done/busy=%b data=%h want 00 0", i, {ls_done, busy}, ls_rdata);
            end
        end
        pulse_ls(0, 1, 2'd2, 32'h106, 0);
        @(negedge clk); ls_req = 0; ls_unsigned = 0;
        n_cmp++;
        if (mem_req !== 1 || mem_addr !== 32'h104) begin
            n_err++; $display("FAIL rst_new_req: got req=%b addr=%h want 1 104", mem_req, mem_addr);
        end
        mem_gnt = 1;
        @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h8001_0000;
        @(negedge clk); mem_rvalid = 0;
        n_cmp++;
        if (ls_done !== 1 || ls_error !== 0 || ls_rdata !== 32'h0000_8001) begin
            n_err++; $display("FAIL rst_new_done: got done=%b err=%b data=%h want 1 0 00008001", ls_done, ls_error, ls_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_fetch_priority();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
